// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS instruction sequencer and datapath control
//
// Sequences one instruction at a time through fetch, decode, execute, memory
// and write-back steps, driving every datapath select and write enable.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   opcode, funct        instruction fields from the instruction register
//   memReady             memory finished the current read/write this cycle
//   pcWrite..regDst      single-bit datapath controls
//   pcSource             00 ALU result, 01 ALUOut, 10 jump target
//   aluSrcB              00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   aluControlOut        ALU operation select
//   instrDone            pulse on the last cycle of each instruction
//   error                sticky illegal opcode/funct flag
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       memToReg,
    output logic       irWrite,
    output logic       aluSrcA,
    output logic       regWrite,
    output logic       regDst,
    output logic [1:0] pcSource,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluControlOut,
    output logic       instrDone,
    output logic       error
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_JUMP, S_ERROR
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       alu_used;
    logic [3:0] alu_ctrl;
    logic       funct_legal;

    always_comb begin
        funct_legal = 1'b0;
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
            default: funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        irWrite     = 1'b0;
        aluSrcA     = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        pcSource    = 2'b00;
        aluSrcB     = 2'b00;
        instrDone   = 1'b0;
        error       = 1'b0;
        alu_op      = 2'b00;
        alu_used    = 1'b0;
        case (state)
            S_FETCH: begin
                memRead  = 1'b1;
                aluSrcB  = 2'b01;
                alu_used = 1'b1;
                // PC and IR only update on the cycle memory actually returns data
                irWrite  = memReady;
                pcWrite  = memReady;
                if (memReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB  = 2'b11;
                alu_used = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = funct_legal ? S_EXECUTE : S_ERROR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                alu_used   = 1'b1;
                state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (memReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                regWrite   = 1'b1;
                memToReg   = 1'b1;
                instrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                // memWrite is held through wait states; memory commits on memReady
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = memReady;
                if (memReady) state_next = S_FETCH;
            end
            S_EXECUTE: begin
                aluSrcA    = 1'b1;
                alu_op     = 2'b10;
                alu_used   = 1'b1;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite   = 1'b1;
                regDst     = 1'b1;
                instrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                alu_op      = 2'b01;
                alu_used    = 1'b1;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                instrDone   = 1'b1;
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                pcWrite    = 1'b1;
                pcSource   = 2'b10;
                instrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_ERROR: begin
                error      = 1'b1;
                state_next = S_ERROR;
            end
            default: state_next = S_FETCH;
        endcase

        // Reset suppresses every output in the same cycle, so an aborted
        // instruction can never leave a write enable asserted.
        if (reset) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            iorD        = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            memToReg    = 1'b0;
            irWrite     = 1'b0;
            aluSrcA     = 1'b0;
            regWrite    = 1'b0;
            regDst      = 1'b0;
            pcSource    = 2'b00;
            aluSrcB     = 2'b00;
            instrDone   = 1'b0;
            error       = 1'b0;
            alu_used    = 1'b0;
        end
    end

    always_comb begin
        alu_ctrl = 4'b1111;
        case (alu_op)
            2'b00: alu_ctrl = 4'b0010;
            2'b01: alu_ctrl = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: alu_ctrl = 4'b0010;
                    6'b100010: alu_ctrl = 4'b0110;
                    6'b100100: alu_ctrl = 4'b0000;
                    6'b100101: alu_ctrl = 4'b0001;
                    6'b101010: alu_ctrl = 4'b0111;
                    default:   alu_ctrl = 4'b1111;
                endcase
            end
            default: alu_ctrl = 4'b1111;
        endcase
    end

    // States that do not use the ALU drive a quiet all-zero operation code
    assign aluControlOut = alu_used ? alu_ctrl : 4'b0000;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven and sequence checks for multicycle_control
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
    logic       irWrite, aluSrcA, regWrite, regDst, instrDone, error;
    logic [1:0] pcSource, aluSrcB;
    logic [3:0] aluControlOut;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .memReady(memReady), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
        .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .irWrite(irWrite), .aluSrcA(aluSrcA), .regWrite(regWrite), .regDst(regDst),
        .pcSource(pcSource), .aluSrcB(aluSrcB), .aluControlOut(aluControlOut),
        .instrDone(instrDone), .error(error)
    );

    // {pcWrite,pcWriteCond,iorD,memRead,memWrite,memToReg,irWrite,aluSrcA,
    //  regWrite,regDst,pcSource,aluSrcB,aluControlOut,instrDone,error}
    logic [19:0] obs;
    assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
                  aluSrcA, regWrite, regDst, pcSource, aluSrcB, aluControlOut,
                  instrDone, error};

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    // Expected output patterns per state, built bit by bit from the state table
    localparam logic [19:0] E_ZERO   = 20'h00000;
    localparam logic [19:0] E_FETCH  = {10'b1001001000, 2'b00, 2'b01, 4'b0010, 2'b00};
    localparam logic [19:0] E_FWAIT  = {10'b0001000000, 2'b00, 2'b01, 4'b0010, 2'b00};
    localparam logic [19:0] E_DECODE = {10'b0000000000, 2'b00, 2'b11, 4'b0010, 2'b00};
    localparam logic [19:0] E_MEMADR = {10'b0000000100, 2'b00, 2'b10, 4'b0010, 2'b00};
    localparam logic [19:0] E_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 4'b0000, 2'b00};
    localparam logic [19:0] E_MEMWB  = {10'b0000010010, 2'b00, 2'b00, 4'b0000, 2'b10};
    localparam logic [19:0] E_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 4'b0000, 2'b10};
    localparam logic [19:0] E_MWWAIT = {10'b0010100000, 2'b00, 2'b00, 4'b0000, 2'b00};
    localparam logic [19:0] E_ALUWB  = {10'b0000000011, 2'b00, 2'b00, 4'b0000, 2'b10};
    localparam logic [19:0] E_BRANCH = {10'b0100000100, 2'b01, 2'b00, 4'b0110, 2'b10};
    localparam logic [19:0] E_JUMP   = {10'b1000000000, 2'b10, 2'b00, 4'b0000, 2'b10};
    localparam logic [19:0] E_ERROR  = {10'b0000000000, 2'b00, 2'b00, 4'b0000, 2'b01};

    function automatic logic [19:0] e_exec(input logic [3:0] alu);
        return {10'b0000000100, 2'b00, 2'b00, alu, 2'b00};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                           input logic rdy, input logic [19:0] exp);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic add_rtype(input logic [5:0] fn, input logic [3:0] alu);
        add_vec(1'b0, OP_R, fn, 1'b1, E_FETCH);
        add_vec(1'b0, OP_R, fn, 1'b1, E_DECODE);
        add_vec(1'b0, OP_R, fn, 1'b1, e_exec(alu));
        add_vec(1'b0, OP_R, fn, 1'b1, E_ALUWB);
    endtask

    // Apply inputs just after a rising edge, compare at the falling edge
    task automatic step(input string name, input logic rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic rdy, input logic [19:0] exp);
        reset = rst; opcode = op; funct = fn; memReady = rdy;
        @(negedge clock);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %b want %b", name, obs, exp);
        end
        @(posedge clock);
        #1;
    endtask

    // instrDone must never be high on two consecutive cycles
    logic prev_done = 1'b0;
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            n_checks++;
            if (prev_done && instrDone) begin
                n_fail++;
                $display("FAIL instrDone_consecutive: got 1 after 1 want 0");
            end
        end
        prev_done <= instrDone;
    end

    int rw_count;
    int cyc;

    initial begin
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; memReady = 1'b1;
        @(posedge clock);
        #1;

        add_vec(1'b1, OP_R, F_ADD, 1'b1, E_ZERO);
        add_rtype(F_ADD, 4'b0010);
        add_rtype(F_SUB, 4'b0110);
        add_vec(1'b0, OP_SW, 6'd0, 1'b1, E_FETCH);
        add_vec(1'b0, OP_SW, 6'd0, 1'b1, E_DECODE);
        add_vec(1'b0, OP_SW, 6'd0, 1'b1, E_MEMADR);
        add_vec(1'b0, OP_SW, 6'd0, 1'b1, E_MEMWR);
        add_vec(1'b0, OP_BEQ, 6'd0, 1'b1, E_FETCH);
        add_vec(1'b0, OP_BEQ, 6'd0, 1'b1, E_DECODE);
        add_vec(1'b0, OP_BEQ, 6'd0, 1'b1, E_BRANCH);
        add_vec(1'b0, OP_J, 6'd0, 1'b1, E_FETCH);
        add_vec(1'b0, OP_J, 6'd0, 1'b1, E_DECODE);
        add_vec(1'b0, OP_J, 6'd0, 1'b1, E_JUMP);
        add_rtype(F_AND, 4'b0000);
        add_rtype(F_OR, 4'b0001);
        add_rtype(F_SLT, 4'b0111);
        add_vec(1'b0, OP_R, F_ADD, 1'b0, E_FWAIT);
        add_vec(1'b0, OP_R, F_ADD, 1'b0, E_FWAIT);
        add_rtype(F_ADD, 4'b0010);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].fn,
                 vecs[i].rdy, vecs[i].exp);
        end

        // lw with two wait cycles in MEMRD: seven cycles, one register write
        rw_count = 0;
        step("lw_fetch",  1'b0, OP_LW, 6'd0, 1'b1, E_FETCH);
        step("lw_decode", 1'b0, OP_LW, 6'd0, 1'b1, E_DECODE);
        step("lw_memadr", 1'b0, OP_LW, 6'd0, 1'b1, E_MEMADR);
        for (int i = 0; i < 3; i++) begin
            reset = 1'b0; memReady = (i == 2);
            @(negedge clock);
            n_checks++;
            if (obs !== E_MEMRD) begin
                n_fail++;
                $display("FAIL lw_memrd%0d: outputs got %b want %b", i, obs, E_MEMRD);
            end
            if (regWrite) rw_count++;
            @(posedge clock);
            #1;
        end
        reset = 1'b0; memReady = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs !== E_MEMWB) begin
            n_fail++;
            $display("FAIL lw_memwb: outputs got %b want %b", obs, E_MEMWB);
        end
        if (regWrite) rw_count++;
        @(posedge clock);
        #1;
        n_checks++;
        if (rw_count != 1) begin
            n_fail++;
            $display("FAIL lw_regwrite_count: got %0d want 1", rw_count);
        end
        step("lw_next_fetch", 1'b0, OP_SW, 6'd0, 1'b1, E_FETCH);

        // sw stalls in MEMWR, then reset aborts it before the write lands
        step("swr_decode", 1'b0, OP_SW, 6'd0, 1'b1, E_DECODE);
        step("swr_memadr", 1'b0, OP_SW, 6'd0, 1'b1, E_MEMADR);
        step("swr_wait0",  1'b0, OP_SW, 6'd0, 1'b0, E_MWWAIT);
        step("swr_wait1",  1'b0, OP_SW, 6'd0, 1'b0, E_MWWAIT);
        step("swr_reset0", 1'b1, OP_SW, 6'd0, 1'b1, E_ZERO);
        step("swr_reset1", 1'b1, OP_SW, 6'd0, 1'b1, E_ZERO);
        step("swr_refetch", 1'b0, OP_SW, 6'd0, 1'b0, E_FWAIT);

        // Illegal opcode locks into ERROR until reset
        step("eop_fetch",  1'b0, 6'b111111, 6'd0, 1'b1, E_FETCH);
        step("eop_decode", 1'b0, 6'b111111, 6'd0, 1'b1, E_DECODE);
        for (cyc = 0; cyc < 10; cyc++) begin
            step($sformatf("eop_err%0d", cyc), 1'b0, OP_R, F_ADD, cyc[0], E_ERROR);
        end
        step("eop_reset", 1'b1, OP_R, 6'd0, 1'b1, E_ZERO);

        // Illegal R-type funct also traps
        step("efn_fetch",  1'b0, OP_R, 6'b000111, 1'b1, E_FETCH);
        step("efn_decode", 1'b0, OP_R, 6'b000111, 1'b1, E_DECODE);
        for (cyc = 0; cyc < 10; cyc++) begin
            step($sformatf("efn_err%0d", cyc), 1'b0, OP_R, 6'b000111, 1'b1, E_ERROR);
        end
        step("efn_reset", 1'b1, OP_R, 6'd0, 1'b1, E_ZERO);
        step("efn_clear", 1'b0, OP_J, 6'd0, 1'b1, E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
